// File: rtl/shift_pkg.sv
// Shared types and defaults for the iterative shifter.
// Configuration macro ITER_SHIFTER_DOUBLE_STEP_EN (used by iter_shifter) selects two bit-steps per cycle.
package shift_pkg;

    localparam int SHIFT_WIDTH = 8;
    localparam int SHIFT_AMT_W = 4;

    typedef struct packed {
        logic ar;
        logic lr;
        logic rot;
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } iter_state_t;

    // Number of 1-bit steps needed: rotates wrap modulo the width, shifts saturate at the width
    // (beyond that point every further step just pushes in more fill bits).
    function automatic int unsigned eff_count(input int unsigned n, input logic rot,
                                              input int unsigned w);
        if (rot) begin
            return n % w;
        end
        return (n > w) ? w : n;
    endfunction

endpackage

// File: rtl/iter_shifter_if.sv
// Request/response bundle of the iterative shifter.
// master = requester side, slave = shifter side.
interface iter_shifter_if
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH,
    parameter int AMT_W = SHIFT_AMT_W
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic             in_ar;
    logic             in_lr;
    logic             in_rot;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_amt, in_ar, in_lr, in_rot, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_ar, in_lr, in_rot, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/shift_step.sv
// One combinational 1-bit shift/rotate step.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH
)(
    input  logic [WIDTH-1:0] d,
    input  shift_op_t        op,
    output logic [WIDTH-1:0] q
);

    // Select the single-bit move; rotate wins over arithmetic, left ignores arithmetic.
    always_comb begin
        q = d;
        if (op.rot) begin
            q = op.lr ? {d[WIDTH-2:0], d[WIDTH-1]} : {d[0], d[WIDTH-1:1]};
        end else if (op.lr) begin
            q = {d[WIDTH-2:0], 1'b0};
        end else begin
            q = {op.ar & d[WIDTH-1], d[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/iter_shifter.sv
// Iterative (bit-serial) shift/rotate unit with valid/ready handshakes.
// Define ITER_SHIFTER_DOUBLE_STEP_EN to apply two bit-steps per SHIFT cycle; results are
// identical in both builds, only latency changes.
module iter_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH,
    parameter int AMT_W = SHIFT_AMT_W
)(
    input  logic          clk,
    input  logic          nrst,
    iter_shifter_if.slave bus
);

    localparam int          CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned W_U   = WIDTH;

    iter_state_t      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    shift_op_t        op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    logic [AMT_W-1:0] amt;
    logic [CNT_W-1:0] k_cnt;
    logic [WIDTH-1:0] step1;
    logic [WIDTH-1:0] step_res;

    assign amt   = bus.in_amt;
    assign k_cnt = CNT_W'(eff_count(32'(amt), bus.in_rot, W_U));

    shift_step #(.WIDTH(WIDTH)) u_step1 (
        .d  (data_q),
        .op (op_q),
        .q  (step1)
    );

`ifdef ITER_SHIFTER_DOUBLE_STEP_EN
    logic [WIDTH-1:0] step2;

    shift_step #(.WIDTH(WIDTH)) u_step2 (
        .d  (step1),
        .op (op_q),
        .q  (step2)
    );
`endif

    // Next-state and next-output logic for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        step_res    = step1;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    data_d     = bus.in_data;
                    op_d       = '{ar: bus.in_ar, lr: bus.in_lr, rot: bus.in_rot};
                    cnt_d      = k_cnt;
                    in_ready_d = 1'b0;
                    if (k_cnt == '0) begin
                        // Nothing to move: present the operand unchanged on the next cycle.
                        state_d     = DONE;
                        out_data_d  = bus.in_data;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end

            SHIFT: begin
`ifdef ITER_SHIFTER_DOUBLE_STEP_EN
                // A lone remaining step must not be doubled.
                if (cnt_q == CNT_W'(1)) begin
                    step_res = step1;
                    cnt_d    = '0;
                end else begin
                    step_res = step2;
                    cnt_d    = cnt_q - CNT_W'(2);
                end
`else
                step_res = step1;
                cnt_d    = cnt_q - CNT_W'(1);
`endif
                data_d = step_res;
                if (cnt_d == '0) begin
                    state_d     = DONE;
                    out_data_d  = step_res;
                    out_valid_d = 1'b1;
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end

            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // Control state and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Working operand and captured operation; only meaningful while SHIFT is active.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        op_q   <= op_d;
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule
